// File: rtl/rb_pkg.sv
// Shared encodings for the parametrised register bank: write-source select codes and clear FSM states.
`timescale 1ns/1ps
package rb_pkg;

  localparam logic [2:0] SRC_INA   = 3'd0;
  localparam logic [2:0] SRC_INB   = 3'd1;
  localparam logic [2:0] SRC_CONST = 3'd2;
  localparam logic [2:0] SRC_ALU   = 3'd3;
  localparam logic [2:0] SRC_MOVE  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  // Codes above SRC_MOVE are reserved and cause the write to be dropped.
  function automatic logic src_valid(input logic [2:0] sel);
    return (sel <= SRC_MOVE);
  endfunction

endpackage

// File: rtl/rb_clear_seq.sv
// Bulk-clear sequencer: walks the register index from 0 to NREGS-1, one register per cycle,
// then emits a single-cycle done pulse. Requests arriving while a clear is running are ignored.
`timescale 1ns/1ps
module rb_clear_seq
  import rb_pkg::*;
#(
  parameter  int NREGS  = 16,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        // NREGS is a power of two, so the counter wraps back to 0 on the last step.
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == ADDR_W'(NREGS - 1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign busy     = (r_state == ST_CLEAR);
  assign clr_en   = (r_state == ST_CLEAR);
  assign clr_done = (r_state == ST_DONE);
  assign clr_addr = r_cnt;

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised register bank: 5-source write port, two combinational read ports, r0 tap, dirty mask,
// sequential bulk clear (writes dropped while busy). RB_WR_BYPASS_EN enables same-cycle write forwarding.
`timescale 1ns/1ps
module reg_bank_param
  import rb_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NREGS  = 16,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        src_sel,
  input  logic [DATA_W-1:0] InA,
  input  logic [DATA_W-1:0] InB,
  input  logic [DATA_W-1:0] CUconst,
  input  logic [DATA_W-1:0] ALUout,
  input  logic [ADDR_W-1:0] mv_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] ALUinA,
  output logic [DATA_W-1:0] ALUinB,
  output logic [DATA_W-1:0] Out,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic [NREGS-1:0]  dirty,
  output logic              wr_drop
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_dirty;
  logic              r_wr_drop;

  logic              w_busy;
  logic              w_clr_en;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_ok;
  logic [DATA_W-1:0] w_wr_dat;

  rb_clear_seq #(
    .NREGS(NREGS)
  ) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .clr_req (clr_req),
    .busy    (w_busy),
    .clr_done(clr_done),
    .clr_en  (w_clr_en),
    .clr_addr(w_clr_addr)
  );

  assign w_wr_ok = we && !w_busy && src_valid(src_sel);

  always_comb begin
    w_wr_dat = '0;
    case (src_sel)
      SRC_INA:   w_wr_dat = InA;
      SRC_INB:   w_wr_dat = InB;
      SRC_CONST: w_wr_dat = CUconst;
      SRC_ALU:   w_wr_dat = ALUout;
      SRC_MOVE:  w_wr_dat = r_regs[mv_addr];
      default:   w_wr_dat = '0;
    endcase
  end

  // Clear and write never collide: writes are only accepted when the sequencer is not clearing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_dirty   <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= we && !w_wr_ok;
      if (w_clr_en) begin
        r_regs[w_clr_addr]  <= '0;
        r_dirty[w_clr_addr] <= 1'b0;
      end else if (w_wr_ok) begin
        r_regs[wr_addr]  <= w_wr_dat;
        r_dirty[wr_addr] <= 1'b1;
      end
    end
  end

`ifdef RB_WR_BYPASS_EN
  assign ALUinA = (w_wr_ok && (rd_addr_a == wr_addr)) ? w_wr_dat : r_regs[rd_addr_a];
  assign ALUinB = (w_wr_ok && (rd_addr_b == wr_addr)) ? w_wr_dat : r_regs[rd_addr_b];
  assign Out    = (w_wr_ok && (wr_addr == '0))        ? w_wr_dat : r_regs[0];
`else
  assign ALUinA = r_regs[rd_addr_a];
  assign ALUinB = r_regs[rd_addr_b];
  assign Out    = r_regs[0];
`endif

  assign busy    = w_busy;
  assign dirty   = r_dirty;
  assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_reg_bank_param.sv
// Randomised and directed bench for reg_bank_param, checked against an array-based reference model.
`timescale 1ns/1ps
module tb_reg_bank_param;

  localparam int DW = 8;
  localparam int NR = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          we = 1'b0;
  logic          clr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] mv_addr = '0;
  logic [AW-1:0] rd_addr_a = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic [2:0]    src_sel = '0;
  logic [DW-1:0] InA = '0;
  logic [DW-1:0] InB = '0;
  logic [DW-1:0] CUconst = '0;
  logic [DW-1:0] ALUout = '0;
  logic [DW-1:0] ALUinA;
  logic [DW-1:0] ALUinB;
  logic [DW-1:0] Out;
  logic          busy;
  logic          clr_done;
  logic          wr_drop;
  logic [NR-1:0] dirty;

  always #5 clk = ~clk;

  reg_bank_param #(.DATA_W(DW), .NREGS(NR)) dut (
    .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr), .src_sel(src_sel),
    .InA(InA), .InB(InB), .CUconst(CUconst), .ALUout(ALUout), .mv_addr(mv_addr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .ALUinA(ALUinA), .ALUinB(ALUinB),
    .Out(Out), .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .dirty(dirty),
    .wr_drop(wr_drop)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: m_clr is -1 when idle, k (0..NR-1) while clearing register k, NR in the done cycle.
  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_dirty;
  int            m_clr;
  bit            m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit m_busy();
    return (m_clr >= 0) && (m_clr < NR);
  endfunction

  function automatic bit m_accept();
    return we && !m_busy() && (src_sel <= 3'd4);
  endfunction

  function automatic logic [DW-1:0] m_src();
    case (src_sel)
      3'd0:    return InA;
      3'd1:    return InB;
      3'd2:    return CUconst;
      3'd3:    return ALUout;
      3'd4:    return m_regs[mv_addr];
      default: return '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
`ifdef RB_WR_BYPASS_EN
    if (m_accept() && (a == wr_addr)) return m_src();
`endif
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_dirty = '0;
    m_clr   = -1;
    m_drop  = 1'b0;
  endtask

  task automatic model_edge();
    bit            acc;
    bit            bsy;
    logic [DW-1:0] d;
    acc = m_accept();
    bsy = m_busy();
    d   = m_src();
    m_drop = we && !acc;
    if (bsy) begin
      m_regs[m_clr]  = '0;
      m_dirty[m_clr] = 1'b0;
      m_clr++;
    end else if (m_clr == NR) begin
      m_clr = -1;
    end else if (clr_req) begin
      m_clr = 0;
    end
    if (acc) begin
      m_regs[wr_addr]  = d;
      m_dirty[wr_addr] = 1'b1;
    end
  endtask

  task automatic settle();
    #1;
    chk("ALUinA", ALUinA, m_read(rd_addr_a));
    chk("ALUinB", ALUinB, m_read(rd_addr_b));
    chk("Out", Out, m_read(4'd0));
    chk("dirty", dirty, m_dirty);
    chk("busy", busy, m_busy());
    chk("clr_done", clr_done, (m_clr == NR));
    chk("wr_drop", wr_drop, m_drop);
  endtask

  task automatic clock();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic write(input logic [2:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; src_sel = sel; wr_addr = a;
    InA = d; InB = d; CUconst = d; ALUout = d;
    settle();
    clock();
    we = 1'b0;
  endtask

  int nb;
  int nd;
  bit seen;

  initial begin
    model_reset();
    @(negedge clk);
    settle();
    chk("rst_dirty", dirty, 16'h0000);
    reset = 1'b1;
    clock();

    // Write then read back, and move between registers.
    write(3'd0, 4'd3, 8'h5A);
    rd_addr_a = 4'd3;
    settle();
    chk("t1_rd", ALUinA, 8'h5A);
    chk("t1_dirty", dirty, 16'h0008);
    we = 1'b1; src_sel = 3'd4; mv_addr = 4'd3; wr_addr = 4'd7; InA = 8'h00;
    settle();
    clock();
    we = 1'b0; rd_addr_a = 4'd7; rd_addr_b = 4'd3;
    settle();
    chk("t2_r7", ALUinA, 8'h5A);
    chk("t2_r3", ALUinB, 8'h5A);
    chk("t2_dirty", dirty, 16'h0088);

    // Full clear with a write attempted mid-clear.
    for (int i = 0; i < NR; i++) write(3'($urandom_range(0, 3)), 4'(i), 8'($urandom_range(1, 255)));
    clr_req = 1'b1;
    settle();
    clock();
    clr_req = 1'b0;
    nb = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (k == 3) begin we = 1'b1; src_sel = 3'd0; wr_addr = 4'd0; InA = 8'hA5; end
      else we = 1'b0;
      settle();
      if (k == 4) chk("t3_wr_drop", wr_drop, 1'b1);
      if (busy) nb++;
      if (clr_done) seen = 1'b1;
      else clock();
    end
    chk("t3_busy_cycles", nb, NR);
    chk("t3_done_seen", seen, 1'b1);
    clock();
    for (int i = 0; i < NR; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(i);
      settle();
      chk("t3_zero", ALUinA, 8'h00);
    end
    chk("t3_dirty", dirty, 16'h0000);

    // Reserved source code is dropped.
    write(3'd0, 4'd2, 8'h11);
    we = 1'b1; src_sel = 3'd6; wr_addr = 4'd2; InA = 8'hEE; InB = 8'hEE; CUconst = 8'hEE; ALUout = 8'hEE;
    settle();
    clock();
    we = 1'b0; rd_addr_a = 4'd2;
    settle();
    chk("t4_wr_drop", wr_drop, 1'b1);
    chk("t4_r2", ALUinA, 8'h11);
    chk("t4_dirty", dirty, 16'h0004);
    clock();
    settle();
    chk("t4_drop_clear", wr_drop, 1'b0);

    // Write to r0 together with a clear request.
    we = 1'b1; src_sel = 3'd0; wr_addr = 4'd0; InA = 8'hFF; clr_req = 1'b1;
    settle();
    clock();
    we = 1'b0; clr_req = 1'b0;
    settle();
    chk("t5_out_ff", Out, 8'hFF);
    chk("t5_busy", busy, 1'b1);
    clock();
    settle();
    chk("t5_out_zero", Out, 8'h00);
    for (int k = 0; k < 20; k++) begin settle(); clock(); end

    // Reset in the middle of a clear.
    for (int i = 4; i < NR; i++) write(3'd1, 4'(i), 8'(8'h40 + i));
    clr_req = 1'b1;
    settle();
    clock();
    clr_req = 1'b0;
    for (int k = 0; k < 4; k++) begin settle(); clock(); end
    chk("t6_busy_pre", busy, 1'b1);
    reset = 1'b0;
    model_reset();
    rd_addr_a = 4'd10; rd_addr_b = 4'd15;
    #1;
    chk("t6_rd_a", ALUinA, 8'h00);
    chk("t6_busy", busy, 1'b0);
    chk("t6_dirty", dirty, 16'h0000);
    settle();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      settle();
      if (clr_done) nd++;
      clock();
    end
    chk("t6_no_done", nd, 0);
    we = 1'b1; src_sel = 3'd0; InA = 8'h3C; wr_addr = 4'd1; rd_addr_b = 4'd1;
    settle();
`ifdef RB_WR_BYPASS_EN
    chk("t6_bypass", ALUinB, 8'h3C);
`else
    chk("t6_no_bypass", ALUinB, 8'h00);
`endif
    clock();
    we = 1'b0;
    settle();
    chk("t6_after", ALUinB, 8'h3C);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      we        = ($urandom_range(0, 3) != 0);
      src_sel   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      wr_addr   = 4'($urandom);
      mv_addr   = 4'($urandom);
      rd_addr_a = 4'($urandom);
      rd_addr_b = 4'($urandom);
      InA       = 8'($urandom);
      InB       = 8'($urandom);
      CUconst   = 8'($urandom);
      ALUout    = 8'($urandom);
      clr_req   = ($urandom_range(0, 29) == 0);
      settle();
      clock();
    end
    we = 1'b0; clr_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
